reg_decimal_formatter: RTL and testbench

Sequential binary-to-decimal ASCII formatter that sits directly upstream of the character display stage. It snapshots REGISTER_A, REGISTER_B and PC_COUNTER and converts each to fixed-width decimal ASCII using iterative double-dabble, one bit per clock. Its outputs drop straight into the display's label strings in place of per-value lookup tables, so the full register range (0–65535) is shown instead of 0–20.

---
 rtl/reg_decimal_formatter_if.sv | 23 ++
 rtl/reg_decimal_formatter.sv | 177 +++++++++++++++++
 tb/tb_reg_decimal_formatter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/reg_decimal_formatter_if.sv
// Bus between the register formatter and its requester: request, operands, ASCII results and status.
interface reg_decimal_formatter_if;
    logic        REG_SIGNAL;
    logic [15:0] REGISTER_A;
    logic [15:0] REGISTER_B;
    logic [4:0]  PC_COUNTER;
    logic [39:0] A_ASCII;
    logic [39:0] B_ASCII;
    logic [15:0] PC_ASCII;
    logic        busy;
    logic        done;
    logic        valid;

    modport master (
        output REG_SIGNAL, REGISTER_A, REGISTER_B, PC_COUNTER,
        input  A_ASCII, B_ASCII, PC_ASCII, busy, done, valid
    );

    modport slave (
        input  REG_SIGNAL, REGISTER_A, REGISTER_B, PC_COUNTER,
        output A_ASCII, B_ASCII, PC_ASCII, busy, done, valid
    );
endinterface

// File: rtl/reg_decimal_formatter.sv
// Snapshots A, B and PC and converts each to decimal ASCII by one-bit-per-clock double-dabble.
// Optional leading-zero blanking of the ASCII outputs: define REG_SIGNAL_BLANK_EN.
module reg_decimal_formatter (
    input  logic                     CLK,
    input  logic                     reset,
    reg_decimal_formatter_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_STORE,
        S_DONE
    } state_t;

`ifdef REG_SIGNAL_BLANK_EN
    localparam logic [39:0] RST_ASCII5 = 40'h2020202030;
    localparam logic [15:0] RST_ASCII2 = 16'h2030;

    // Blank zero digits above the first non-zero one; the units digit always prints.
    function automatic logic [39:0] fmt5(input logic [19:0] bcd);
        logic        lead;
        logic [3:0]  nib;
        int unsigned d;
        lead = 1'b1;
        fmt5 = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            d   = 4 - i;
            nib = bcd[d*4 +: 4];
            if (lead && (nib == 4'd0) && (d != 0)) begin
                fmt5[d*8 +: 8] = 8'h20;
            end else begin
                lead = 1'b0;
                fmt5[d*8 +: 8] = {4'h3, nib};
            end
        end
    endfunction

    function automatic logic [15:0] fmt2(input logic [7:0] bcd);
        fmt2 = {(bcd[7:4] == 4'd0) ? 8'h20 : {4'h3, bcd[7:4]}, {4'h3, bcd[3:0]}};
    endfunction
`else
    localparam logic [39:0] RST_ASCII5 = 40'h3030303030;
    localparam logic [15:0] RST_ASCII2 = 16'h3030;

    function automatic logic [39:0] fmt5(input logic [19:0] bcd);
        fmt5 = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            fmt5[i*8 +: 8] = {4'h3, bcd[i*4 +: 4]};
        end
    endfunction

    function automatic logic [15:0] fmt2(input logic [7:0] bcd);
        fmt2 = {4'h3, bcd[7:4], 4'h3, bcd[3:0]};
    endfunction
`endif

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_index;
    logic [3:0]  r_count;
    logic [15:0] r_snap_a;
    logic [15:0] r_snap_b;
    logic [4:0]  r_snap_pc;
    logic [15:0] r_bin;
    logic [19:0] r_bcd;
    logic [19:0] r_stage_a;
    logic [19:0] r_stage_b;
    logic [7:0]  r_stage_pc;
    logic [39:0] r_a_ascii;
    logic [39:0] r_b_ascii;
    logic [15:0] r_pc_ascii;
    logic        r_done;
    logic        r_valid;
    logic        w_busy;
    logic [15:0] w_snap_sel;
    logic [19:0] w_bcd_adj;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.REG_SIGNAL) w_next = S_LOAD;
            S_LOAD:  w_next = S_SHIFT;
            S_SHIFT: if (r_count == 4'd15) w_next = S_STORE;
            S_STORE: w_next = (r_index == 2'd2) ? S_DONE : S_LOAD;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != S_IDLE);
    end

    always_comb begin
        case (r_index)
            2'd0:    w_snap_sel = r_snap_a;
            2'd1:    w_snap_sel = r_snap_b;
            default: w_snap_sel = {11'd0, r_snap_pc};
        endcase
    end

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int unsigned i = 0; i < 5; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_index    <= '0;
            r_count    <= '0;
            r_snap_a   <= '0;
            r_snap_b   <= '0;
            r_snap_pc  <= '0;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_stage_a  <= '0;
            r_stage_b  <= '0;
            r_stage_pc <= '0;
            r_a_ascii  <= RST_ASCII5;
            r_b_ascii  <= RST_ASCII5;
            r_pc_ascii <= RST_ASCII2;
            r_done     <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_done <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (bus.REG_SIGNAL) begin
                        r_snap_a  <= bus.REGISTER_A;
                        r_snap_b  <= bus.REGISTER_B;
                        r_snap_pc <= bus.PC_COUNTER;
                        r_index   <= '0;
                    end
                end
                S_LOAD: begin
                    r_bin   <= w_snap_sel;
                    r_bcd   <= '0;
                    r_count <= '0;
                end
                S_SHIFT: begin
                    {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
                    r_count        <= r_count + 4'd1;
                end
                S_STORE: begin
                    case (r_index)
                        2'd0:    r_stage_a  <= r_bcd;
                        2'd1:    r_stage_b  <= r_bcd;
                        default: r_stage_pc <= r_bcd[7:0];
                    endcase
                    if (r_index != 2'd2) r_index <= r_index + 2'd1;
                end
                S_DONE: begin
                    r_a_ascii  <= fmt5(r_stage_a);
                    r_b_ascii  <= fmt5(r_stage_b);
                    r_pc_ascii <= fmt2(r_stage_pc);
                    r_valid    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.A_ASCII  = r_a_ascii;
    assign bus.B_ASCII  = r_b_ascii;
    assign bus.PC_ASCII = r_pc_ascii;
    assign bus.busy     = w_busy;
    assign bus.done     = r_done;
    assign bus.valid    = r_valid;
endmodule

// File: tb/tb_reg_decimal_formatter.sv
// Directed and random checks of reg_decimal_formatter against a divide/modulo decimal model.
module tb_reg_decimal_formatter;
    logic clk = 1'b0;
    logic rst;
    int   n_asserts = 0;
    int   n_fail    = 0;

    always #5 clk = ~clk;

    reg_decimal_formatter_if bus();

    reg_decimal_formatter dut (
        .CLK   (clk),
        .reset (rst),
        .bus   (bus)
    );

    // Decimal digits by repeated division; five ASCII bytes, units in the low byte.
    function automatic logic [39:0] ref_ascii(input int unsigned v);
        int unsigned dg[5];
        int unsigned x;
        bit          lead;
        logic [39:0] r;
        x = v;
        for (int k = 0; k < 5; k++) begin
            dg[k] = x % 10;
            x     = x / 10;
        end
        lead = 1'b1;
        r    = '0;
        for (int k = 4; k >= 0; k--) begin
`ifdef REG_SIGNAL_BLANK_EN
            if (lead && dg[k] == 0 && k != 0) begin
                r[k*8 +: 8] = 8'h20;
            end else begin
                lead = 1'b0;
                r[k*8 +: 8] = 8'h30 + 8'(dg[k]);
            end
`else
            r[k*8 +: 8] = 8'h30 + 8'(dg[k]);
`endif
        end
        return r;
    endfunction

    function automatic logic [15:0] ref_pc(input int unsigned v);
        logic [39:0] full;
        full = ref_ascii(v);
        return full[15:0];
    endfunction

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents a request for one cycle; returns at the negedge following the sampling edge.
    task automatic start(input int unsigned a, input int unsigned b, input int unsigned pc);
        @(negedge clk);
        bus.REGISTER_A = 16'(a);
        bus.REGISTER_B = 16'(b);
        bus.PC_COUNTER = 5'(pc);
        bus.REG_SIGNAL = 1'b1;
        @(negedge clk);
        bus.REG_SIGNAL = 1'b0;
    endtask

    task automatic wait_done(input int start_cyc, output int cyc);
        cyc = start_cyc;
        while (bus.done !== 1'b1 && cyc < 150) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic count_dones(input int ncyc, output int n);
        n = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) n++;
        end
    endtask

    task automatic full_conv(input string tag, input int unsigned a, input int unsigned b,
                             input int unsigned pc);
        int cyc;
        start(a, b, pc);
        check({tag, "_busy"}, 40'(bus.busy), 40'd1);
        wait_done(0, cyc);
        check({tag, "_latency"}, 40'(cyc), 40'd55);
        check({tag, "_busy_at_done"}, 40'(bus.busy), 40'd0);
        check({tag, "_A"}, bus.A_ASCII, ref_ascii(a));
        check({tag, "_B"}, bus.B_ASCII, ref_ascii(b));
        check({tag, "_PC"}, 40'(bus.PC_ASCII), 40'(ref_pc(pc)));
        check({tag, "_valid"}, 40'(bus.valid), 40'd1);
        @(negedge clk);
        check({tag, "_done_single"}, 40'(bus.done), 40'd0);
    endtask

    initial begin
        int          cyc;
        int          n;
        int          gap;
        int unsigned a;

        bus.REG_SIGNAL = 1'b0;
        bus.REGISTER_A = '0;
        bus.REGISTER_B = '0;
        bus.PC_COUNTER = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state, no request
        check("rst_A", bus.A_ASCII, ref_ascii(0));
        check("rst_B", bus.B_ASCII, ref_ascii(0));
        check("rst_PC", 40'(bus.PC_ASCII), 40'(ref_pc(0)));
        check("rst_valid", 40'(bus.valid), 40'd0);
        check("rst_busy", 40'(bus.busy), 40'd0);
        check("rst_done", 40'(bus.done), 40'd0);

        full_conv("basic", 12345, 20, 31);
        full_conv("extreme", 65535, 0, 0);

        // Request during busy is dropped and inputs after the snapshot are ignored
        start(5, 1, 3);
        repeat (10) @(negedge clk);
        bus.REGISTER_A = 16'd999;
        bus.REG_SIGNAL = 1'b1;
        @(negedge clk);
        bus.REG_SIGNAL = 1'b0;
        wait_done(11, cyc);
        check("ignore_latency", 40'(cyc), 40'd55);
        check("ignore_A", bus.A_ASCII, ref_ascii(5));
        count_dones(70, n);
        check("ignore_no_second_done", 40'(n), 40'd0);

        // Reset mid-conversion
        start(7, 8, 9);
        repeat (20) @(negedge clk);
        check("midrst_busy_before", 40'(bus.busy), 40'd1);
        rst = 1'b1;
        #1;
        check("midrst_busy", 40'(bus.busy), 40'd0);
        check("midrst_A", bus.A_ASCII, ref_ascii(0));
        check("midrst_B", bus.B_ASCII, ref_ascii(0));
        check("midrst_PC", 40'(bus.PC_ASCII), 40'(ref_pc(0)));
        check("midrst_valid", 40'(bus.valid), 40'd0);
        check("midrst_done", 40'(bus.done), 40'd0);
        @(negedge clk);
        rst = 1'b0;
        count_dones(70, n);
        check("midrst_no_done", 40'(n), 40'd0);
        full_conv("after_rst", 4321, 60000, 17);

        // REG_SIGNAL held high: back-to-back conversions
        a = 100;
        @(negedge clk);
        bus.REGISTER_A = 16'(a);
        bus.REGISTER_B = 16'd77;
        bus.PC_COUNTER = 5'd12;
        bus.REG_SIGNAL = 1'b1;
        for (int it = 0; it < 4; it++) begin
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (bus.done !== 1'b1 && gap < 200);
            check("b2b_period", 40'(gap), 40'd56);
            check("b2b_A", bus.A_ASCII, ref_ascii(a));
            a = a + 1;
            bus.REGISTER_A = 16'(a);
            if (it == 3) bus.REG_SIGNAL = 1'b0;
        end
        count_dones(70, n);
        check("b2b_stop", 40'(n), 40'd0);

        // Random operands
        for (int it = 0; it < 6; it++) begin
            full_conv("rand", $urandom_range(0, 65535), $urandom_range(0, 65535),
                      $urandom_range(0, 31));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
